// File: rtl/if_buf_writer.sv
// Streams row_len*num_rows contiguous words from a registered-read memory into the IF buffer,
// tagging each word with start-of-row / end-of-row flags and honouring buffer back-pressure.
module if_buf_writer #(
    parameter int IF_SCRATCH_WIDTH = 16,
    parameter int IF_ADDR_LEN      = 5,
    parameter int ROW_CNT_LEN      = 8,
    parameter int MEM_ADDR_LEN     = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [MEM_ADDR_LEN-1:0]       base_addr,
    input  logic [IF_ADDR_LEN-1:0]        row_len,
    input  logic [ROW_CNT_LEN-1:0]        num_rows,
    output logic                          mem_ren,
    output logic [MEM_ADDR_LEN-1:0]       mem_raddr,
    input  logic [IF_SCRATCH_WIDTH-1:0]   mem_rdata,
    input  logic                          IF_buf_full,
    output logic                          IF_buf_write,
    output logic [IF_SCRATCH_WIDTH+1:0]   IF_buf_wdata,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_PUSH, S_DONE} state_t;

    localparam logic [IF_ADDR_LEN-1:0]  LEN_ONE  = IF_ADDR_LEN'(1);
    localparam logic [ROW_CNT_LEN-1:0]  ROW_ONE  = ROW_CNT_LEN'(1);
    localparam logic [MEM_ADDR_LEN-1:0] ADDR_ONE = MEM_ADDR_LEN'(1);

    state_t                        r_state;
    logic [MEM_ADDR_LEN-1:0]       r_addr;
    logic [IF_ADDR_LEN-1:0]        r_len;
    logic [ROW_CNT_LEN-1:0]        r_rows;
    logic [IF_ADDR_LEN-1:0]        r_word;
    logic [ROW_CNT_LEN-1:0]        r_row;
    logic [IF_SCRATCH_WIDTH-1:0]   r_hold;
    logic                          r_rd_pend;
    logic                          r_busy;
    logic                          r_done;

    logic                          w_write;
    logic                          w_last_word;
    logic                          w_last_xfer;
    logic                          w_sor;
    logic [IF_SCRATCH_WIDTH-1:0]   w_data;

    // Fresh read data bypasses the hold register so a word can be pushed the cycle it arrives;
    // the hold register keeps it for as long as the buffer stalls.
    assign w_data       = r_rd_pend ? mem_rdata : r_hold;
    assign w_last_word  = (r_word == (r_len - LEN_ONE));
    assign w_last_xfer  = w_last_word && (r_row == (r_rows - ROW_ONE));
    assign w_sor        = (r_word == '0);
    assign w_write      = (r_state == S_PUSH) && !IF_buf_full;

    assign IF_buf_write = w_write;
    assign IF_buf_wdata = {w_sor, w_last_word, w_data};
    assign mem_ren      = (r_state == S_READ) || (w_write && !w_last_xfer);
    assign mem_raddr    = w_write ? (r_addr + ADDR_ONE) : r_addr;
    assign busy         = r_busy;
    assign done         = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_rows    <= '0;
            r_word    <= '0;
            r_row     <= '0;
            r_hold    <= '0;
            r_rd_pend <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_rd_pend <= mem_ren;
            if (r_rd_pend) begin
                r_hold <= mem_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if ((row_len != '0) && (num_rows != '0)) begin
                            r_addr  <= base_addr;
                            r_len   <= row_len;
                            r_rows  <= num_rows;
                            r_word  <= '0;
                            r_row   <= '0;
                            r_state <= S_READ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_PUSH;
                end
                S_PUSH: begin
                    if (w_write) begin
                        if (w_last_xfer) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_addr <= r_addr + ADDR_ONE;
                            if (w_last_word) begin
                                r_word <= '0;
                                r_row  <= r_row + ROW_ONE;
                            end else begin
                                r_word <= r_word + LEN_ONE;
                            end
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/if_buf_writer.md
IF_BUF_WRITER -- requirements
Module: if_buf_writer

Interface
REQ-001 Parameter IF_SCRATCH_WIDTH, default 16, data word width in bits.
REQ-002 Parameter IF_ADDR_LEN, default 5, width of the row-length field.
REQ-003 Parameter ROW_CNT_LEN, default 8, width of the row-count field.
REQ-004 Parameter MEM_ADDR_LEN, default 10, width of the source-memory address.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-008 base_addr  input  MEM_ADDR_LEN  first source address, latched on accepted start.
REQ-009 row_len  input  IF_ADDR_LEN  words per row, latched on accepted start.
REQ-010 num_rows  input  ROW_CNT_LEN  rows per transfer, latched on accepted start.
REQ-011 mem_ren  output  1  source-memory read strobe.
REQ-012 mem_raddr  output  MEM_ADDR_LEN  source-memory read address.
REQ-013 mem_rdata  input  IF_SCRATCH_WIDTH  read data, valid exactly one cycle after mem_ren.
REQ-014 IF_buf_full  input  1  IF buffer cannot accept a write this cycle.
REQ-015 IF_buf_write  output  1  IF buffer write strobe.
REQ-016 IF_buf_wdata  output  IF_SCRATCH_WIDTH+2  bits[W-1:0] data, bit[W] end-of-row, bit[W+1] start-of-row (W = IF_SCRATCH_WIDTH).
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle completion pulse.

Function
REQ-019 States: IDLE, READ, PUSH, DONE; reset state IDLE.
REQ-020 IDLE: start=1 with row_len!=0 and num_rows!=0 -> latch base_addr/row_len/num_rows, clear word and row counters, go to READ.
REQ-021 IDLE: start=1 with row_len==0 or num_rows==0 -> go to DONE, no reads, no writes.
REQ-022 READ: mem_ren=1, mem_raddr=current address; next state PUSH unconditionally.
REQ-023 Hold register loads mem_rdata in the cycle following every mem_ren=1 cycle and only then.
REQ-024 PUSH: IF_buf_wdata driven from hold register plus tags; IF_buf_write = !IF_buf_full.
REQ-025 PUSH with IF_buf_full=1: no write, no read, all counters/address/hold held; remain in PUSH.
REQ-026 PUSH write accepted, word not last of transfer: same cycle mem_ren=1 at address+1, counters advance, remain in PUSH -> sustained one word per cycle.
REQ-027 PUSH write accepted on last word of transfer: mem_ren=0, go to DONE.
REQ-028 Start-of-row tag = 1 iff word counter == 0; end-of-row tag = 1 iff word counter == row_len-1; both set when row_len==1.
REQ-029 Word counter wraps to 0 after row_len-1 and increments row counter; transfer ends when last word of row num_rows-1 is accepted.
REQ-030 Address increments by 1 per accepted word, contiguous across rows, wraps modulo 2^MEM_ADDR_LEN.
REQ-031 DONE: done=1 for one cycle, then IDLE; start in DONE, READ, or PUSH ignored.
REQ-032 IF_buf_write never asserted outside PUSH; IF_buf_wdata is don't-care when IF_buf_write=0 but is driven, never X after reset.
REQ-033 Total writes per transfer exactly row_len*num_rows; no word skipped or duplicated under any IF_buf_full pattern.

Reset
REQ-034 rst=1 at any edge, including mid-transfer, -> IDLE; mem_ren, IF_buf_write, busy, done = 0; counters, address, hold, and latched fields = 0.
REQ-035 The first start is accepted in the cycle after rst deasserts; a transfer interrupted by reset is not resumed.

Verification
REQ-036 row_len=3, num_rows=2, base=0x010, mem[a]=a, full=0 -> start, then read at 0x010; writes start in the cycle after; 6 writes on consecutive cycles: data 0x10..0x15, tags {SOR,EOR} = 10,00,01,10,00,01; done 1 cycle after last write.
REQ-037 Same transfer, IF_buf_full=1 on cycles 2-4 of PUSH -> write stalls, no mem_ren while full; sequence identical, done delayed by 3 cycles.
REQ-038 row_len=1, num_rows=3 -> 3 writes, each with both tags=1.
REQ-039 row_len=0 or num_rows=0 -> done pulse 1 cycle after start; zero mem_ren, zero writes.
REQ-040 base=0x3FE, row_len=4, num_rows=1 -> addresses 0x3FE,0x3FF,0x000,0x001.
REQ-041 rst asserted after 2 of 6 writes -> next cycle IDLE, all outputs 0; new start runs a full fresh transfer correctly.
